load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_W, default 6, width of the data-memory word address.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: req_valid  input  1  CPU request present.
REQ-005 Port: req_ready  output  1  unit can accept a request this cycle.
REQ-006 Port: req_we  input  1  1 = store, 0 = load.
REQ-007 Port: req_addr  input  32  byte address.
REQ-008 Port: req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 Port: req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-010 Port: req_wdata  input  32  store data, right-justified.
REQ-011 Port: rsp_valid  output  1  one-cycle pulse marking request completion.
REQ-012 Port: rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 Port: rsp_err  output  1  request rejected; valid only with rsp_valid.
REQ-014 Port: mem_read  output  1  read enable to the data memory.
REQ-015 Port: mem_write  output  1  write enable to the data memory; the memory commits on the clk edge.
REQ-016 Port: mem_addr  output  ADDR_W  word address, equal to captured req_addr[ADDR_W+1:2].
REQ-017 Port: mem_wdata  output  32  full word to be written.
REQ-018 Port: mem_rdata  input  32  combinational read data from the memory.

Function
REQ-019 The unit SHALL accept a request only on a cycle where req_valid and req_ready are both 1, and SHALL capture all req_* fields on that edge.
REQ-020 The unit SHALL implement the states IDLE, READ, WRITE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 The unit SHALL flag an error if req_size is 11, if a halfword has addr[0]=1, if a word has addr[1:0]!=00, or if addr[31:ADDR_W+2] is nonzero.
REQ-022 An erroneous request SHALL go from IDLE to RESP with no memory access, giving rsp_valid=1, rsp_err=1 and rsp_rdata=0 one cycle after acceptance.
REQ-023 A load SHALL go IDLE->READ->RESP, drive mem_read=1 only in READ, register mem_rdata at the end of READ, and give rsp_valid two cycles after acceptance.
REQ-024 A word store SHALL go IDLE->WRITE->RESP, with mem_write=1 and mem_wdata=req_wdata in WRITE, and give rsp_valid two cycles after acceptance.
REQ-025 A byte or halfword store SHALL go IDLE->READ->WRITE->RESP; the WRITE word SHALL be the READ word with only the addressed lanes replaced, and rsp_valid SHALL come three cycles after acceptance.
REQ-026 Byte lanes SHALL be little-endian: offset 0 maps to bits 7:0, and a halfword at offset 2 maps to bits 31:16.
REQ-027 Loads SHALL extract the addressed lanes and extend them to 32 bits according to req_unsigned; a word load returns the word unchanged.
REQ-028 RESP SHALL last exactly one cycle and then return to IDLE, so a back-to-back request is accepted no earlier than the cycle after RESP.
REQ-029 mem_read and mem_write SHALL never both be 1, and both SHALL be 0 in IDLE and RESP.
REQ-030 rsp_rdata and rsp_err SHALL hold their values between responses.

Reset
REQ-031 While rst=1, the state SHALL become IDLE on the next edge; rsp_valid, rsp_err and rsp_rdata SHALL become 0, and req_ready SHALL be 1 from the first cycle after reset.
REQ-032 mem_read and mem_write SHALL be forced to 0 combinationally during any cycle with rst=1, so that reset mid-operation never commits a partial store.
REQ-033 A request aborted by reset SHALL produce no response.

Structure
REQ-034 The size encodings, the state encoding and the lane-offset constants SHALL live in a shared package, lsu_pkg.
REQ-035 Lane extraction, extension and store merging SHALL form one combinational sub-module, lsu_align, instantiated once.

Verification
REQ-036 Load word: memory word 1 = 0x00000005; load word at address 0x04 -> mem_read for one cycle with mem_addr=1, then rsp_rdata=0x00000005 two cycles after acceptance.
REQ-037 Signed byte load: word 3 = 0x80FF7F01; signed byte at 0x0D -> rsp_rdata=0x0000007F; signed byte at 0x0E -> 0xFFFFFFFF; unsigned byte at 0x0F -> 0x00000080.
REQ-038 Halfword store: word 2 = 0x00000019; store halfword 0xABCD to 0x0A -> one mem_read, then one mem_write with mem_wdata=0xABCD0019, then rsp_valid three cycles after acceptance.
REQ-039 Errors: word load at 0x06, halfword store at 0x01, req_size=11, and address 0x100 -> each gives rsp_err=1 one cycle after acceptance with no mem_read or mem_write.
REQ-040 Reset in WRITE: assert rst during the WRITE cycle of a word store -> mem_write=0 that cycle, memory is unchanged, no rsp_valid is produced, and req_ready=1 in the next cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// little-endian byte-lane positions, plus small decode helpers.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_READ  = 2'b01;
  localparam logic [1:0] ST_WRITE = 2'b10;
  localparam logic [1:0] ST_RESP  = 2'b11;

  localparam logic [4:0] LANE0_LSB = 5'd0;
  localparam logic [4:0] LANE1_LSB = 5'd8;
  localparam logic [4:0] LANE2_LSB = 5'd16;
  localparam logic [4:0] LANE3_LSB = 5'd24;

  // Bit position of the lowest bit of the lane at byte offset off.
  function automatic logic [4:0] lane_lsb(input logic [1:0] off);
    logic [4:0] lsb;
    case (off)
      2'd0:    lsb = LANE0_LSB;
      2'd1:    lsb = LANE1_LSB;
      2'd2:    lsb = LANE2_LSB;
      2'd3:    lsb = LANE3_LSB;
      default: lsb = LANE0_LSB;
    endcase
    return lsb;
  endfunction

  // Illegal size or misalignment for the given size and low address bits.
  function automatic logic access_error(input logic [1:0] size, input logic [1:0] off);
    logic err;
    case (size)
      SIZE_BYTE: err = 1'b0;
      SIZE_HALF: err = off[0];
      SIZE_WORD: err = (off != 2'b00);
      default:   err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data, and merges
// sub-word store data into the previously read memory word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word_i,
  input  logic [31:0] base_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);

  logic [4:0]  byte_lsb_s;
  logic [4:0]  half_lsb_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select, sign/zero extension and store merge.
  always_comb begin
    byte_lsb_s = lane_lsb(offset_i);
    half_lsb_s = lane_lsb({offset_i[1], 1'b0});
    byte_s     = rd_word_i[byte_lsb_s +: 8];
    half_s     = rd_word_i[half_lsb_s +: 16];
    ld_data_o  = 32'd0;
    st_word_o  = base_word_i;
    case (size_i)
      SIZE_BYTE: begin
        ld_data_o = unsigned_i ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
        st_word_o[byte_lsb_s +: 8] = wdata_i[7:0];
      end
      SIZE_HALF: begin
        ld_data_o = unsigned_i ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
        st_word_o[half_lsb_s +: 16] = wdata_i[15:0];
      end
      SIZE_WORD: begin
        ld_data_o = rd_word_i;
        st_word_o = wdata_i;
      end
      default: begin
        ld_data_o = 32'd0;
        st_word_o = base_word_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time over a word-wide data memory,
// using read-modify-write for byte and halfword stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic [1:0]        state_q, state_d;
  logic              we_q;
  logic [ADDR_W+1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [31:0]       rsp_rdata_q;
  logic              accept_s;
  logic              req_err_s;
  logic [31:0]       ld_data_s;
  logic [31:0]       st_word_s;

  assign req_ready = (state_q == ST_IDLE);
  assign accept_s  = req_valid && req_ready;
  assign req_err_s = access_error(req_size, req_addr[1:0]) ||
                     ((req_addr >> (ADDR_W + 2)) != 32'd0);

  // Gated by rst so a reset mid-operation never commits a partial store.
  assign mem_read  = (state_q == ST_READ)  && !rst;
  assign mem_write = (state_q == ST_WRITE) && !rst;
  assign mem_addr  = addr_q[ADDR_W+1:2];
  assign mem_wdata = st_word_s;

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  lsu_align u_align (
    .rd_word_i   (mem_rdata),
    .base_word_i (word_q),
    .wdata_i     (wdata_q),
    .offset_i    (addr_q[1:0]),
    .size_i      (size_q),
    .unsigned_i  (uns_q),
    .ld_data_o   (ld_data_s),
    .st_word_o   (st_word_s)
  );

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (req_err_s)                   state_d = ST_RESP;
          else if (!req_we)                state_d = ST_READ;
          else if (req_size == SIZE_WORD)  state_d = ST_WRITE;
          else                             state_d = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (we_q) state_d = ST_WRITE;
        else      state_d = ST_RESP;
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, captured request, read word and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      addr_q      <= {(ADDR_W+2){1'b0}};
      size_q      <= SIZE_BYTE;
      uns_q       <= 1'b0;
      wdata_q     <= 32'd0;
      word_q      <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept_s) begin
        we_q    <= req_we;
        addr_q  <= req_addr[ADDR_W+1:0];
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
      end
      if (state_q == ST_READ) begin
        word_q <= mem_rdata;
      end
      rsp_valid_q <= (state_d == ST_RESP);
      // Response fields change only when entering RESP, otherwise they hold.
      if (state_d == ST_RESP) begin
        rsp_err_q   <= (state_q == ST_IDLE);
        rsp_rdata_q <= (state_q == ST_READ && !we_q) ? ld_data_s : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word memory model and a
// response scoreboard checked through immediate assertions.
module tb_load_store_unit;

  localparam int ADDR_W = 6;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] wdata;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic [31:0] mem [64];
  logic        mem_init;
  exp_t        sb_q[$];
  int          n_assert;
  int          n_fail;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
      mem[1] <= 32'h0000_0005;
      mem[2] <= 32'h0000_0019;
      mem[3] <= 32'h80FF_7F01;
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic err, input logic [31:0] rdata, input int lat,
                        input int nrd, input int nwr, input logic [31:0] exp_wd);
    exp_t        e;
    exp_t        got;
    int          cyc;
    int          rd_cnt;
    int          wr_cnt;
    logic        both;
    logic [31:0] wd_seen;
    e.err = err; e.rdata = rdata; e.lat = lat; e.nrd = nrd; e.nwr = nwr; e.wdata = exp_wd;
    @(negedge clk);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; rd_cnt = 0; wr_cnt = 0; both = 1'b0; wd_seen = 32'd0;
    while (rsp_valid !== 1'b1 && cyc < 8) begin
      if (mem_read === 1'b1) rd_cnt++;
      if (mem_write === 1'b1) begin
        wr_cnt++;
        wd_seen = mem_wdata;
      end
      if (mem_read === 1'b1 && mem_write === 1'b1) both = 1'b1;
      @(negedge clk);
      cyc++;
    end
    got = sb_q.pop_front();
    check({tag, "_latency"}, 32'(cyc), 32'(got.lat));
    check({tag, "_err"}, 32'(rsp_err), 32'(got.err));
    check({tag, "_rdata"}, rsp_rdata, got.rdata);
    check({tag, "_reads"}, 32'(rd_cnt), 32'(got.nrd));
    check({tag, "_writes"}, 32'(wr_cnt), 32'(got.nwr));
    if (got.nwr > 0) check({tag, "_wdata"}, wd_seen, got.wdata);
    check({tag, "_rw_excl"}, 32'(both), 32'd0);
    check({tag, "_resp_memidle"}, {30'd0, mem_read, mem_write}, 32'd0);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
    check({tag, "_hold_rdata"}, rsp_rdata, got.rdata);
    check({tag, "_hold_err"}, 32'(rsp_err), 32'(got.err));
  endtask

  initial begin
    int stray;
    n_assert = 0; n_fail = 0;
    rst = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_size = 2'b00;
    req_unsigned = 1'b0; req_wdata = 32'd0;

    @(negedge clk);
    check("rst_memrd", 32'(mem_read), 32'd0);
    check("rst_memwr", 32'(mem_write), 32'd0);
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    rst = 1'b0; mem_init = 1'b0;

    // tag, we, addr, size, uns, wdata, err, rdata, lat, nrd, nwr, exp_wdata
    do_req("ldw_04",  1'b0, 32'h04, 2'b10, 1'b0, 32'd0, 1'b0, 32'h0000_0005, 2, 1, 0, 32'd0);
    do_req("ldsb_0d", 1'b0, 32'h0D, 2'b00, 1'b0, 32'd0, 1'b0, 32'h0000_007F, 2, 1, 0, 32'd0);
    do_req("ldsb_0e", 1'b0, 32'h0E, 2'b00, 1'b0, 32'd0, 1'b0, 32'hFFFF_FFFF, 2, 1, 0, 32'd0);
    do_req("ldub_0f", 1'b0, 32'h0F, 2'b00, 1'b1, 32'd0, 1'b0, 32'h0000_0080, 2, 1, 0, 32'd0);
    do_req("ldsh_0e", 1'b0, 32'h0E, 2'b01, 1'b0, 32'd0, 1'b0, 32'hFFFF_80FF, 2, 1, 0, 32'd0);
    do_req("lduh_0c", 1'b0, 32'h0C, 2'b01, 1'b1, 32'd0, 1'b0, 32'h0000_7F01, 2, 1, 0, 32'd0);
    do_req("sth_0a",  1'b1, 32'h0A, 2'b01, 1'b0, 32'h0000_ABCD, 1'b0, 32'd0, 3, 1, 1, 32'hABCD_0019);
    do_req("ldw_08a", 1'b0, 32'h08, 2'b10, 1'b0, 32'd0, 1'b0, 32'hABCD_0019, 2, 1, 0, 32'd0);
    do_req("stb_09",  1'b1, 32'h09, 2'b00, 1'b0, 32'hFFFF_FF5A, 1'b0, 32'd0, 3, 1, 1, 32'hABCD_5A19);
    do_req("ldw_08b", 1'b0, 32'h08, 2'b10, 1'b0, 32'd0, 1'b0, 32'hABCD_5A19, 2, 1, 0, 32'd0);
    do_req("stw_10",  1'b1, 32'h10, 2'b10, 1'b0, 32'h1234_5678, 1'b0, 32'd0, 2, 0, 1, 32'h1234_5678);
    do_req("ldw_10",  1'b0, 32'h10, 2'b10, 1'b0, 32'd0, 1'b0, 32'h1234_5678, 2, 1, 0, 32'd0);
    do_req("err_ldw_06",  1'b0, 32'h06,  2'b10, 1'b0, 32'd0, 1'b1, 32'd0, 1, 0, 0, 32'd0);
    do_req("err_sth_01",  1'b1, 32'h01,  2'b01, 1'b0, 32'h0000_1111, 1'b1, 32'd0, 1, 0, 0, 32'd0);
    do_req("err_size11",  1'b0, 32'h00,  2'b11, 1'b0, 32'd0, 1'b1, 32'd0, 1, 0, 0, 32'd0);
    do_req("err_addr100", 1'b0, 32'h100, 2'b10, 1'b0, 32'd0, 1'b1, 32'd0, 1, 0, 0, 32'd0);

    // Reset asserted during the WRITE cycle of a word store to word 5.
    @(negedge clk);
    check("rstw_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h14; req_size = 2'b10;
    req_unsigned = 1'b0; req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstw_in_write", 32'(mem_write), 32'd1);
    rst = 1'b1;
    #1;
    check("rstw_write_gated", 32'(mem_write), 32'd0);
    check("rstw_read_gated", 32'(mem_read), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("rstw_ready_after", 32'(req_ready), 32'd1);
    check("rstw_mem_unchanged", mem[5], 32'd0);
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid !== 1'b0) stray++;
      @(negedge clk);
    end
    check("rstw_no_rsp", 32'(stray), 32'd0);
    do_req("ldw_14", 1'b0, 32'h14, 2'b10, 1'b0, 32'd0, 1'b0, 32'd0, 2, 1, 0, 32'd0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
